// File: rtl/reg_file_access_scheduler_pkg.sv
// Shared constants and requester-select encoding for the register-file access scheduler.
package reg_file_access_scheduler_pkg;

    localparam int          DATA_WIDTH = 16;
    localparam int          ADDR_WIDTH = 4;
    localparam int          OPCODE_W   = 16;
    localparam logic [7:0]  READ_OP    = 8'h22;
    localparam logic [7:0]  WRITE_OP   = 8'h92;
    localparam logic [15:0] NOP_OPCODE = 16'h0000;
    localparam logic [3:0]  ALU_NIBBLE = 4'b0001;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RES,
        SEL_LD,
        SEL_ALU,
        SEL_DBG
    } sel_e;

endpackage

// File: rtl/reg_file_access_scheduler_if.sv
// Requester-side bundle: four valid/ready handshakes plus the operand and debug responses.
interface reg_file_access_scheduler_if #(
    parameter int DATA_WIDTH = reg_file_access_scheduler_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_file_access_scheduler_pkg::ADDR_WIDTH
);
    logic                  alu_rd_valid;
    logic                  alu_rd_ready;
    logic [15:0]           alu_opcode;
    logic [ADDR_WIDTH-1:0] alu_src1;
    logic [ADDR_WIDTH-1:0] alu_src2;
    logic [ADDR_WIDTH-1:0] alu_dst;
    logic [DATA_WIDTH-1:0] alu_operand_a;
    logic [DATA_WIDTH-1:0] alu_operand_b;
    logic                  alu_operand_valid;

    logic                  res_valid;
    logic                  res_ready;
    logic [ADDR_WIDTH-1:0] res_addr;
    logic [DATA_WIDTH-1:0] res_data;

    logic                  ld_valid;
    logic                  ld_ready;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_data;

    logic                  dbg_valid;
    logic                  dbg_ready;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_data;
    logic                  dbg_data_valid;

    modport master (
        output alu_rd_valid, alu_opcode, alu_src1, alu_src2, alu_dst,
        output res_valid, res_addr, res_data,
        output ld_valid, ld_addr, ld_data,
        output dbg_valid, dbg_addr,
        input  alu_rd_ready, res_ready, ld_ready, dbg_ready,
        input  alu_operand_a, alu_operand_b, alu_operand_valid,
        input  dbg_data, dbg_data_valid
    );

    modport slave (
        input  alu_rd_valid, alu_opcode, alu_src1, alu_src2, alu_dst,
        input  res_valid, res_addr, res_data,
        input  ld_valid, ld_addr, ld_data,
        input  dbg_valid, dbg_addr,
        output alu_rd_ready, res_ready, ld_ready, dbg_ready,
        output alu_operand_a, alu_operand_b, alu_operand_valid,
        output dbg_data, dbg_data_valid
    );

endinterface

// File: rtl/reg_file_access_scheduler_scoreboard.sv
// Pending-write scoreboard: one bit per register between ALU issue and result writeback.
module reg_scoreboard #(
    parameter int ADDR_WIDTH = reg_file_access_scheduler_pkg::ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     set_en,
    input  logic [ADDR_WIDTH-1:0]    set_addr,
    input  logic                     clr_en,
    input  logic [ADDR_WIDTH-1:0]    clr_addr,
    input  logic [ADDR_WIDTH-1:0]    lookup_a,
    input  logic [ADDR_WIDTH-1:0]    lookup_b,
    input  logic [ADDR_WIDTH-1:0]    lookup_c,
    output logic                     hit_a,
    output logic                     hit_b,
    output logic                     hit_c,
    output logic [2**ADDR_WIDTH-1:0] pending_mask,
    output logic                     err_unexpected_result
);

    assign hit_a = pending_mask[lookup_a];
    assign hit_b = pending_mask[lookup_b];
    assign hit_c = pending_mask[lookup_c];

    // A result for a register nobody issued is still written, but flagged permanently.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_mask          <= '0;
            err_unexpected_result <= 1'b0;
        end else begin
            if (set_en)
                pending_mask[set_addr] <= 1'b1;
            if (clr_en) begin
                pending_mask[clr_addr] <= 1'b0;
                if (!pending_mask[clr_addr])
                    err_unexpected_result <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file_access_scheduler.sv
// Single-port arbiter in front of the register file: one grant per cycle, registered RF bus,
// read data captured at the end of the bus cycle and returned one cycle later.
module reg_file_access_scheduler #(
    parameter int         DATA_WIDTH   = reg_file_access_scheduler_pkg::DATA_WIDTH,
    parameter int         ADDR_WIDTH   = reg_file_access_scheduler_pkg::ADDR_WIDTH,
    parameter int         STARVE_LIMIT = 8,
    parameter logic [7:0] READ_OP      = reg_file_access_scheduler_pkg::READ_OP,
    parameter logic [7:0] WRITE_OP     = reg_file_access_scheduler_pkg::WRITE_OP
) (
    input  logic                     clk,
    input  logic                     reset,
    reg_file_access_scheduler_if.slave req,
    output logic [15:0]              rf_opcode,
    output logic [ADDR_WIDTH-1:0]    rf_addr_1,
    output logic [ADDR_WIDTH-1:0]    rf_addr_2,
    output logic [ADDR_WIDTH-1:0]    rf_addr_3,
    output logic [DATA_WIDTH-1:0]    rf_write_data,
    output logic                     rf_write_enable,
    input  logic [DATA_WIDTH-1:0]    rf_read_data_1,
    input  logic [DATA_WIDTH-1:0]    rf_read_data_2,
    input  logic [DATA_WIDTH-1:0]    rf_read_data_reg,
    output logic [2**ADDR_WIDTH-1:0] pending_mask,
    output logic                     err_unexpected_result
);
    import reg_file_access_scheduler_pkg::*;

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    sel_e                  sel;
    logic [WAIT_W-1:0]     dbg_wait;
    logic                  starved;
    logic                  hit_1, hit_2, hit_3;
    logic                  alu_hazard, ld_hazard;
    logic                  alu_vld_p1, dbg_vld_p1;
    logic                  alu_vld_p2, dbg_vld_p2;
    logic [DATA_WIDTH-1:0] rd_a_p2, rd_b_p2, rd_reg_p2;

    reg_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
        .clk                   (clk),
        .reset                 (reset),
        .set_en                (sel == SEL_ALU),
        .set_addr              (req.alu_dst),
        .clr_en                (sel == SEL_RES),
        .clr_addr              (req.res_addr),
        .lookup_a              (req.alu_src1),
        .lookup_b              (req.alu_src2),
        .lookup_c              (req.alu_dst),
        .hit_a                 (hit_1),
        .hit_b                 (hit_2),
        .hit_c                 (hit_3),
        .pending_mask          (pending_mask),
        .err_unexpected_result (err_unexpected_result)
    );

    assign alu_hazard = hit_1 | hit_2 | hit_3;
    assign ld_hazard  = pending_mask[req.ld_addr];
    assign starved    = dbg_wait >= WAIT_W'(STARVE_LIMIT);

    // Blocked requesters fall through so they never stall lower priorities.
    always_comb begin
        sel = SEL_NONE;
        if (!reset) begin
            if (req.dbg_valid && starved)               sel = SEL_DBG;
            else if (req.res_valid)                     sel = SEL_RES;
            else if (req.ld_valid && !ld_hazard)        sel = SEL_LD;
            else if (req.alu_rd_valid && !alu_hazard)   sel = SEL_ALU;
            else if (req.dbg_valid)                     sel = SEL_DBG;
        end
    end

    assign req.res_ready    = (sel == SEL_RES);
    assign req.ld_ready     = (sel == SEL_LD);
    assign req.alu_rd_ready = (sel == SEL_ALU);
    assign req.dbg_ready    = (sel == SEL_DBG);

    always_ff @(posedge clk) begin
        if (reset || !req.dbg_valid || sel == SEL_DBG)
            dbg_wait <= '0;
        else if (!starved)
            dbg_wait <= dbg_wait + 1'b1;
    end

    // p1: register-file bus, driven for the cycle after the grant edge
    always_ff @(posedge clk) begin
        rf_opcode       <= NOP_OPCODE;
        rf_addr_1       <= '0;
        rf_addr_2       <= '0;
        rf_addr_3       <= '0;
        rf_write_data   <= '0;
        rf_write_enable <= 1'b0;
        alu_vld_p1      <= 1'b0;
        dbg_vld_p1      <= 1'b0;
        if (!reset) begin
            unique case (sel)
                SEL_ALU: begin
                    rf_opcode  <= req.alu_opcode;
                    rf_addr_1  <= req.alu_src1;
                    rf_addr_2  <= req.alu_src2;
                    rf_addr_3  <= req.alu_dst;
                    alu_vld_p1 <= 1'b1;
                end
                SEL_RES: begin
                    rf_opcode       <= {WRITE_OP, 8'h00};
                    rf_addr_3       <= req.res_addr;
                    rf_write_data   <= req.res_data;
                    rf_write_enable <= 1'b1;
                end
                SEL_LD: begin
                    rf_opcode       <= {WRITE_OP, 8'h00};
                    rf_addr_3       <= req.ld_addr;
                    rf_write_data   <= req.ld_data;
                    rf_write_enable <= 1'b1;
                end
                SEL_DBG: begin
                    rf_opcode  <= {READ_OP, 8'h00};
                    rf_addr_3  <= req.dbg_addr;
                    dbg_vld_p1 <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // p2: read data sampled at the end of the bus cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_vld_p2 <= 1'b0;
            dbg_vld_p2 <= 1'b0;
        end else begin
            alu_vld_p2 <= alu_vld_p1;
            dbg_vld_p2 <= dbg_vld_p1;
        end
        rd_a_p2   <= rf_read_data_1;
        rd_b_p2   <= rf_read_data_2;
        rd_reg_p2 <= rf_read_data_reg;
    end

    // response outputs: single-cycle pulses, data held until the next response
    always_ff @(posedge clk) begin
        if (reset) begin
            req.alu_operand_valid <= 1'b0;
            req.alu_operand_a     <= '0;
            req.alu_operand_b     <= '0;
            req.dbg_data_valid    <= 1'b0;
            req.dbg_data          <= '0;
        end else begin
            req.alu_operand_valid <= alu_vld_p2;
            req.dbg_data_valid    <= dbg_vld_p2;
            if (alu_vld_p2) begin
                req.alu_operand_a <= rd_a_p2;
                req.alu_operand_b <= rd_b_p2;
            end
            if (dbg_vld_p2)
                req.dbg_data <= rd_reg_p2;
        end
    end

endmodule

// File: tb/tb_reg_file_access_scheduler.sv
// Scoreboard bench for reg_file_access_scheduler with a behavioural 16x16 register file.
module tb_reg_file_access_scheduler;
    import reg_file_access_scheduler_pkg::*;

    localparam int W_RES = 0, W_LD = 1, W_ALU = 2, W_DBG = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rf_opcode;
    logic [3:0]  rf_addr_1, rf_addr_2, rf_addr_3;
    logic [15:0] rf_write_data;
    logic        rf_write_enable;
    logic [15:0] rf_read_data_1, rf_read_data_2, rf_read_data_reg;
    logic [15:0] pending_mask;
    logic        err_unexpected_result;

    reg_file_access_scheduler_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus_if ();

    reg_file_access_scheduler dut (
        .clk                   (clk),
        .reset                 (reset),
        .req                   (bus_if),
        .rf_opcode             (rf_opcode),
        .rf_addr_1             (rf_addr_1),
        .rf_addr_2             (rf_addr_2),
        .rf_addr_3             (rf_addr_3),
        .rf_write_data         (rf_write_data),
        .rf_write_enable       (rf_write_enable),
        .rf_read_data_1        (rf_read_data_1),
        .rf_read_data_2        (rf_read_data_2),
        .rf_read_data_reg      (rf_read_data_reg),
        .pending_mask          (pending_mask),
        .err_unexpected_result (err_unexpected_result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // behavioural register file
    logic [15:0] rf_mem [16];
    logic        rf_load;
    always @(posedge clk) begin
        if (rf_load)
            for (int i = 0; i < 16; i++) rf_mem[i] <= 16'h1000 + 16'(i);
        else if (rf_write_enable)
            rf_mem[rf_addr_3] <= rf_write_data;
    end
    assign rf_read_data_1   = rf_mem[rf_addr_1];
    assign rf_read_data_2   = rf_mem[rf_addr_2];
    assign rf_read_data_reg = rf_mem[rf_addr_3];

    typedef struct { int cyc; logic [44:0] bus; } bus_exp_t;
    typedef struct { int cyc; logic [31:0] data; } rsp_exp_t;

    bus_exp_t    bus_q [$];
    rsp_exp_t    alu_q [$];
    rsp_exp_t    dbg_q [$];
    logic [15:0] ref_mem [16];
    int          cyc = 0;
    logic        mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [44:0] pack_bus(input logic [15:0] op, input logic [3:0] a1,
                                             input logic [3:0] a2, input logic [3:0] a3,
                                             input logic [15:0] wd, input logic we);
        return {op, a1, a2, a3, wd, we};
    endfunction

    function automatic logic rdy(input int who);
        case (who)
            W_RES:   return bus_if.res_ready;
            W_LD:    return bus_if.ld_ready;
            W_ALU:   return bus_if.alu_rd_ready;
            default: return bus_if.dbg_ready;
        endcase
    endfunction

    // expectations are pushed at each observed accept and retired when the DUT responds
    always @(negedge clk) begin
        bus_exp_t be;
        rsp_exp_t re;
        if (!mon_en) begin
            for (int i = 0; i < 16; i++) ref_mem[i] = 16'h1000 + 16'(i);
            bus_q.delete();
            alu_q.delete();
            dbg_q.delete();
        end else begin
            if (bus_q.size() > 0 && bus_q[0].cyc == cyc) begin
                be = bus_q.pop_front();
                check("rf_bus", pack_bus(rf_opcode, rf_addr_1, rf_addr_2, rf_addr_3,
                                         rf_write_data, rf_write_enable), be.bus);
            end else begin
                check("rf_idle", {rf_opcode, rf_write_enable}, 17'h0);
            end
            if (bus_if.alu_operand_valid) begin
                check("alu_rsp_expected", alu_q.size() > 0, 1'b1);
                if (alu_q.size() > 0) begin
                    re = alu_q.pop_front();
                    check("alu_rsp_latency", cyc, re.cyc);
                    check("alu_operands", {bus_if.alu_operand_a, bus_if.alu_operand_b}, re.data);
                end
            end
            if (bus_if.dbg_data_valid) begin
                check("dbg_rsp_expected", dbg_q.size() > 0, 1'b1);
                if (dbg_q.size() > 0) begin
                    re = dbg_q.pop_front();
                    check("dbg_rsp_latency", cyc, re.cyc);
                    check("dbg_data", bus_if.dbg_data, re.data);
                end
            end
            if (reset) begin
                alu_q.delete();
                dbg_q.delete();
            end else begin
                if (bus_if.res_valid && bus_if.res_ready) begin
                    be.cyc = cyc + 1;
                    be.bus = pack_bus({WRITE_OP, 8'h00}, 4'h0, 4'h0, bus_if.res_addr, bus_if.res_data, 1'b1);
                    bus_q.push_back(be);
                    ref_mem[bus_if.res_addr] = bus_if.res_data;
                end
                if (bus_if.ld_valid && bus_if.ld_ready) begin
                    be.cyc = cyc + 1;
                    be.bus = pack_bus({WRITE_OP, 8'h00}, 4'h0, 4'h0, bus_if.ld_addr, bus_if.ld_data, 1'b1);
                    bus_q.push_back(be);
                    ref_mem[bus_if.ld_addr] = bus_if.ld_data;
                end
                if (bus_if.alu_rd_valid && bus_if.alu_rd_ready) begin
                    be.cyc = cyc + 1;
                    be.bus = pack_bus(bus_if.alu_opcode, bus_if.alu_src1, bus_if.alu_src2,
                                      bus_if.alu_dst, 16'h0, 1'b0);
                    bus_q.push_back(be);
                    re.cyc  = cyc + 3;
                    re.data = {ref_mem[bus_if.alu_src1], ref_mem[bus_if.alu_src2]};
                    alu_q.push_back(re);
                end
                if (bus_if.dbg_valid && bus_if.dbg_ready) begin
                    be.cyc = cyc + 1;
                    be.bus = pack_bus({READ_OP, 8'h00}, 4'h0, 4'h0, bus_if.dbg_addr, 16'h0, 1'b0);
                    bus_q.push_back(be);
                    re.cyc  = cyc + 3;
                    re.data = {16'h0, ref_mem[bus_if.dbg_addr]};
                    dbg_q.push_back(re);
                end
            end
        end
    end

    task automatic drop_valid(input int who);
        case (who)
            W_RES:   bus_if.res_valid    = 1'b0;
            W_LD:    bus_if.ld_valid     = 1'b0;
            W_ALU:   bus_if.alu_rd_valid = 1'b0;
            default: bus_if.dbg_valid    = 1'b0;
        endcase
    endtask

    task automatic wait_accept(input int who, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (rdy(who)) done = 1'b1;
        end
        check({tag, "_accepted"}, done, 1'b1);
        @(posedge clk);
        #1;
        drop_valid(who);
    endtask

    task automatic send_res(input logic [3:0] a, input logic [15:0] d, input string tag);
        bus_if.res_addr = a; bus_if.res_data = d; bus_if.res_valid = 1'b1;
        wait_accept(W_RES, tag);
    endtask

    task automatic send_alu(input logic [15:0] op, input logic [3:0] s1, input logic [3:0] s2,
                            input logic [3:0] d, input string tag);
        bus_if.alu_opcode = op; bus_if.alu_src1 = s1; bus_if.alu_src2 = s2; bus_if.alu_dst = d;
        bus_if.alu_rd_valid = 1'b1;
        wait_accept(W_ALU, tag);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_ld;
        bit   got_dbg;
        logic [3:0] exp_rdy;

        reset = 1'b1;
        rf_load = 1'b1;
        bus_if.res_valid = 1'b1; bus_if.res_addr = '0; bus_if.res_data = '0;
        bus_if.ld_valid = 1'b1;  bus_if.ld_addr = '0;  bus_if.ld_data = '0;
        bus_if.alu_rd_valid = 1'b1; bus_if.alu_opcode = '0;
        bus_if.alu_src1 = '0; bus_if.alu_src2 = '0; bus_if.alu_dst = '0;
        bus_if.dbg_valid = 1'b1; bus_if.dbg_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {bus_if.res_ready, bus_if.ld_ready, bus_if.alu_rd_ready, bus_if.dbg_ready}, 4'h0);
        check("rst_mask", pending_mask, 16'h0);
        check("rst_bus", {rf_opcode, rf_addr_1, rf_addr_2, rf_addr_3, rf_write_data, rf_write_enable}, 45'h0);
        check("rst_err", err_unexpected_result, 1'b0);
        check("rst_rsp", {bus_if.alu_operand_a, bus_if.alu_operand_b, bus_if.alu_operand_valid,
                          bus_if.dbg_data, bus_if.dbg_data_valid}, 50'h0);
        bus_if.res_valid = 1'b0; bus_if.ld_valid = 1'b0;
        bus_if.alu_rd_valid = 1'b0; bus_if.dbg_valid = 1'b0;
        reset = 1'b0;
        rf_load = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // load write then debug read of the same register
        bus_if.ld_addr = 4'd5; bus_if.ld_data = 16'hBEEF; bus_if.ld_valid = 1'b1;
        wait_accept(W_LD, "t1_ld");
        bus_if.dbg_addr = 4'd5; bus_if.dbg_valid = 1'b1;
        wait_accept(W_DBG, "t1_dbg");
        repeat (3) @(posedge clk);
        #1;
        check("t1_dbg_data", bus_if.dbg_data, 16'hBEEF);

        // read-after-write hazard held until the result writes back
        send_alu(16'h1234, 4'd1, 4'd2, 4'd7, "t2_alu1");
        check("t2_mask", pending_mask, 16'h0080);
        bus_if.alu_opcode = 16'h1567; bus_if.alu_src1 = 4'd7; bus_if.alu_src2 = 4'd2;
        bus_if.alu_dst = 4'd8; bus_if.alu_rd_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t2_raw_blocked", bus_if.alu_rd_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        send_res(4'd7, 16'h0042, "t2_res");
        check("t2_mask_clear", pending_mask, 16'h0000);
        wait_accept(W_ALU, "t2_alu2");
        check("t2_mask_dst8", pending_mask, 16'h0100);
        repeat (3) @(posedge clk);
        #1;
        check("t2_operand_a", bus_if.alu_operand_a, 16'h0042);
        send_res(4'd8, 16'h0808, "t2_res8");

        // all four requesters at once: res, ld, alu_rd, dbg on consecutive cycles
        send_alu(16'h1111, 4'd1, 4'd2, 4'd9, "t3_alu_pre");
        bus_if.res_addr = 4'd9;  bus_if.res_data = 16'h5555; bus_if.res_valid = 1'b1;
        bus_if.ld_addr  = 4'd11; bus_if.ld_data  = 16'h6666; bus_if.ld_valid  = 1'b1;
        bus_if.alu_opcode = 16'h1ABC; bus_if.alu_src1 = 4'd1; bus_if.alu_src2 = 4'd2;
        bus_if.alu_dst = 4'd12; bus_if.alu_rd_valid = 1'b1;
        bus_if.dbg_addr = 4'd9; bus_if.dbg_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_rdy = 4'b1000 >> i;
            check("t3_grant", {bus_if.res_ready, bus_if.ld_ready, bus_if.alu_rd_ready, bus_if.dbg_ready}, exp_rdy);
            @(posedge clk);
            #1;
            drop_valid(i);
        end
        repeat (3) @(posedge clk);
        #1;
        send_res(4'd12, 16'hC0C0, "t3_res12");
        check("t3_mask_clear", pending_mask, 16'h0000);

        // starvation: debug overtakes a continuous load stream
        bus_if.ld_addr = 4'd13; bus_if.ld_data = 16'hD00D; bus_if.ld_valid = 1'b1;
        bus_if.dbg_addr = 4'd11; bus_if.dbg_valid = 1'b1;
        n_ld = 0;
        got_dbg = 1'b0;
        for (int i = 0; i < 30 && !got_dbg; i++) begin
            @(negedge clk);
            if (bus_if.dbg_ready) got_dbg = 1'b1;
            else if (bus_if.ld_ready) n_ld++;
        end
        check("t4_dbg_granted", got_dbg, 1'b1);
        check("t4_ld_before_dbg", n_ld, 8);
        @(posedge clk);
        #1;
        bus_if.dbg_valid = 1'b0;
        @(negedge clk);
        check("t4_ld_resumes", bus_if.ld_ready, 1'b1);
        @(posedge clk);
        #1;
        bus_if.ld_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // result to a register with no pending write
        check("t5_err_before", err_unexpected_result, 1'b0);
        send_res(4'd3, 16'h0333, "t5_res");
        check("t5_err_set", err_unexpected_result, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("t5_err_held", err_unexpected_result, 1'b1);
        check("t5_written", rf_mem[3], 16'h0333);

        // reset in the cycle after an operand-read grant
        send_alu(16'h1F00, 4'd4, 4'd5, 4'd14, "t6_alu");
        reset = 1'b1;
        bus_if.res_valid = 1'b1; bus_if.ld_valid = 1'b1;
        bus_if.alu_rd_valid = 1'b1; bus_if.dbg_valid = 1'b1;
        @(negedge clk);
        check("t6_ready_in_reset", {bus_if.res_ready, bus_if.ld_ready, bus_if.alu_rd_ready, bus_if.dbg_ready}, 4'h0);
        @(posedge clk);
        #1;
        check("t6_mask", pending_mask, 16'h0000);
        check("t6_opcode", rf_opcode, 16'h0000);
        check("t6_err_cleared", err_unexpected_result, 1'b0);
        @(negedge clk);
        check("t6_ready_in_reset2", {bus_if.res_ready, bus_if.ld_ready, bus_if.alu_rd_ready, bus_if.dbg_ready}, 4'h0);
        @(posedge clk);
        #1;
        check("t6_no_pulse", bus_if.alu_operand_valid, 1'b0);
        bus_if.res_valid = 1'b0; bus_if.ld_valid = 1'b0;
        bus_if.alu_rd_valid = 1'b0; bus_if.dbg_valid = 1'b0;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t6_no_pulse_after", bus_if.alu_operand_valid, 1'b0);
        check("t6_mask_after", pending_mask, 16'h0000);

        check("queues_drained", alu_q.size() + dbg_q.size() + bus_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
